// File: rtl/instr_fetch_sequencer.sv
// PC and fetch controller: issues ROM words to the datapath,
// takes branch redirects and runs timed-NOP idle delays.
module instr_fetch_sequencer #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 28,
    parameter logic [3:0]      NOP_OPC  = 4'd0,
    parameter int              DELAY_W  = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    input  logic               iStall,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchTarget,
    input  logic [INSTR_W-1:0] iRomInstruction,
    output logic [ADDR_W-1:0]  oRomAddress,
    output logic [INSTR_W-1:0] oInstruction,
    output logic               oInstrValid,
    output logic [ADDR_W-1:0]  oPC,
    output logic               oDelayBusy
);

    typedef enum logic {
        FETCH,
        DELAY
    } state_t;

    state_t               st_q, st_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    opc_q, opc_d;
    logic [INSTR_W-1:0]   ins_q, ins_d;
    logic                 vld_q, vld_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;

    logic                 hold;
    logic [3:0]           opcode;
    logic [DELAY_W-1:0]   operand;

    assign hold    = vld_q & iStall;
    assign opcode  = iRomInstruction[INSTR_W-1 -: 4];
    assign operand = iRomInstruction[DELAY_W-1:0];

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        opc_d = opc_q;
        ins_d = ins_q;
        vld_d = vld_q;
        cnt_d = cnt_q;
        if (!hold) begin
            unique case (st_q)
                FETCH: begin
                    // a consumed branch discards this cycle's sequential fetch
                    if (vld_q && iBranchTaken) begin
                        pc_d  = iBranchTarget;
                        vld_d = 1'b0;
                    end else if (iEnable) begin
                        ins_d = iRomInstruction;
                        opc_d = pc_q;
                        vld_d = 1'b1;
                        pc_d  = pc_q + ADDR_W'(1);
                        if (opcode == NOP_OPC && operand != '0) begin
                            st_d  = DELAY;
                            cnt_d = operand;
                        end
                    end else begin
                        vld_d = 1'b0;
                    end
                end
                DELAY: begin
                    vld_d = 1'b0;
                    if (iEnable) begin
                        if (cnt_q == DELAY_W'(1)) begin
                            st_d  = FETCH;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q - DELAY_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            st_q  <= FETCH;
            pc_q  <= RESET_PC;
            opc_q <= '0;
            ins_q <= '0;
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            opc_q <= opc_d;
            ins_q <= ins_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign oRomAddress  = pc_q;
    assign oInstruction = ins_q;
    assign oInstrValid  = vld_q;
    assign oPC          = opc_q;
    assign oDelayBusy   = (st_q == DELAY);

endmodule
